// File: rtl/eth_port_arbiter.sv
// Egress port arbiter: round-robin per-packet grant over NUM_REQ FWFT ingress FIFOs.
// Optional packet-length watchdog enabled by defining ETH_ARB_WDOG_EN.
module eth_port_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_PKT_W = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ*(DATA_W+2)-1:0]    in_data,
  input  logic [NUM_REQ-1:0]               in_empty,
  input  logic [NUM_REQ-1:0]               in_req,
  output logic [NUM_REQ-1:0]               rd_en,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic                             port_stall,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             err_proto
);

  localparam int unsigned WORD_W = DATA_W + 2;
  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned OFF_W  = IDX_W + 1;
`ifdef ETH_ARB_WDOG_EN
  localparam int unsigned CNT_W  = $clog2(MAX_PKT_W + 1);
`endif

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_PKT_W < 1) begin : g_badParam
    $error("eth_port_arbiter: unsupported parameter values");
  end

  typedef struct packed {
    logic              eop;
    logic              sop;
    logic [DATA_W-1:0] data;
  } fifoWord_t;

  typedef enum logic {IDLE, XFER} state_t;

  state_t             stateQ, stateD;
  logic [IDX_W-1:0]   gIdxQ, gIdxD;
  logic [IDX_W-1:0]   rrPtrQ, rrPtrD;
  logic               firstQ, firstD;
  logic [NUM_REQ-1:0] grantD;
  logic               validD, sopD, eopD, errD, stallD;
  logic [DATA_W-1:0]  dataD;
  logic               pop, lastWord;
  logic               anyElig;
  logic [IDX_W-1:0]   pickIdx;
  logic [OFF_W-1:0]   offIdx;
  logic [NUM_REQ-1:0] eligVec;
  fifoWord_t          words [NUM_REQ];
  fifoWord_t          headWord;
`ifdef ETH_ARB_WDOG_EN
  logic [CNT_W-1:0]   cntQ, cntD;
`endif

  // Unpack FIFO heads; only sop-headed packets addressed here may win.
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
    assign words[i]   = fifoWord_t'(in_data[i*WORD_W +: WORD_W]);
    assign eligVec[i] = in_req[i] && !in_empty[i] && words[i].sop;
  end

  // Round-robin pick: scan from the highest offset down so the nearest to rrPtr wins.
  always_comb begin
    anyElig = 1'b0;
    pickIdx = '0;
    offIdx  = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      offIdx = {1'b0, rrPtrQ} + OFF_W'(k);
      if (offIdx >= OFF_W'(NUM_REQ)) offIdx = offIdx - OFF_W'(NUM_REQ);
      if (eligVec[offIdx[IDX_W-1:0]]) begin
        anyElig = 1'b1;
        pickIdx = offIdx[IDX_W-1:0];
      end
    end
  end

  // Next state, pop decision and next output register values.
  always_comb begin
    stateD   = stateQ;
    gIdxD    = gIdxQ;
    rrPtrD   = rrPtrQ;
    firstD   = firstQ;
    grantD   = grant;
    validD   = out_valid;
    dataD    = out_data;
    sopD     = out_sop;
    eopD     = out_eop;
    errD     = 1'b0;
    stallD   = out_valid && !out_ready;
    rd_en    = '0;
    pop      = 1'b0;
    lastWord = 1'b0;
    headWord = words[gIdxQ];
`ifdef ETH_ARB_WDOG_EN
    cntD     = cntQ;
`endif
    if (out_ready) validD = 1'b0;

    case (stateQ)
      IDLE: begin
        if (anyElig) begin
          stateD          = XFER;
          gIdxD           = pickIdx;
          grantD          = '0;
          grantD[pickIdx] = 1'b1;
          firstD          = 1'b1;
`ifdef ETH_ARB_WDOG_EN
          cntD            = '0;
`endif
        end
      end
      XFER: begin
        pop = !in_empty[gIdxQ] && (!out_valid || out_ready);
        if (pop) begin
          rd_en    = grant;
          validD   = 1'b1;
          dataD    = headWord.data;
          sopD     = headWord.sop;
          lastWord = headWord.eop;
          firstD   = 1'b0;
          errD     = headWord.sop && !firstQ;
`ifdef ETH_ARB_WDOG_EN
          cntD = cntQ + CNT_W'(1);
          // Oversized packet: truncate here with a forced eop.
          if (cntD == CNT_W'(MAX_PKT_W) && !headWord.eop) begin
            lastWord = 1'b1;
            errD     = 1'b1;
          end
`endif
          eopD = lastWord;
          if (lastWord) begin
            stateD = IDLE;
            grantD = '0;
            rrPtrD = (gIdxQ == IDX_W'(NUM_REQ - 1)) ? '0 : gIdxQ + IDX_W'(1);
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ     <= IDLE;
      gIdxQ      <= '0;
      rrPtrQ     <= '0;
      firstQ     <= 1'b0;
      grant      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      port_stall <= 1'b0;
      err_proto  <= 1'b0;
`ifdef ETH_ARB_WDOG_EN
      cntQ       <= '0;
`endif
    end else begin
      stateQ     <= stateD;
      gIdxQ      <= gIdxD;
      rrPtrQ     <= rrPtrD;
      firstQ     <= firstD;
      grant      <= grantD;
      out_valid  <= validD;
      out_data   <= dataD;
      out_sop    <= sopD;
      out_eop    <= eopD;
      port_stall <= stallD;
      err_proto  <= errD;
`ifdef ETH_ARB_WDOG_EN
      cntQ       <= cntD;
`endif
    end
  end

endmodule

// File: tb/tb_eth_port_arbiter.sv
// Scoreboard bench for eth_port_arbiter: queue-modelled FIFOs, expected egress words
// queued at stimulus time and checked by an independent egress monitor.
module tb_eth_port_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned WW   = DW + 2;
  localparam int unsigned MAXW = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ*WW-1:0]   in_data;
  logic [NREQ-1:0]      in_empty;
  logic [NREQ-1:0]      in_req;
  logic [NREQ-1:0]      rd_en;
  logic                 out_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 out_sop;
  logic                 out_eop;
  logic                 port_stall;
  logic [NREQ-1:0]      grant;
  logic                 err_proto;

  eth_port_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .MAX_PKT_W(MAXW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_empty(in_empty), .in_req(in_req),
    .rd_en(rd_en), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .port_stall(port_stall), .grant(grant),
    .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] fifo0[$];
  logic [WW-1:0] fifo1[$];
  logic [WW-1:0] expQ[$];
  int nChecks = 0;
  int nFails = 0;
  int cyc = 0;
  int lastEopCyc = -1;
  int gapStart = 0;
  bit gapChk = 1'b0;
  int errCnt = 0;
  int sopCnt0 = 0;
  int sopCnt1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (reset && err_proto) errCnt <= errCnt + 1;

  // Egress monitor: every accepted word must be the next expected one.
  always @(negedge clk) begin
    logic [WW-1:0] got;
    logic [WW-1:0] expw;
    if (reset && out_valid && out_ready) begin
      got = {out_eop, out_sop, out_data};
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_word: got 0x%0h expected nothing (cycle %0d)", got, cyc);
      end else begin
        expw = expQ.pop_front();
        check("out_word", 64'(got), 64'(expw));
        if (out_sop && gapChk && lastEopCyc >= gapStart)
          check("idle_gap", 64'(cyc - lastEopCyc), 64'd2);
      end
      if (out_sop && out_data[31:24] == 8'h00) sopCnt0++;
      if (out_sop && out_data[31:24] == 8'h01) sopCnt1++;
      if (out_eop) lastEopCyc = cyc;
    end
  end

  task automatic refresh();
    in_empty[0]    = (fifo0.size() == 0);
    in_empty[1]    = (fifo1.size() == 0);
    in_data[WW-1:0]    = (fifo0.size() != 0) ? fifo0[0] : '0;
    in_data[2*WW-1:WW] = (fifo1.size() != 0) ? fifo1[0] : '0;
  endtask

  // One clock: FIFO pops follow the pre-edge rd_en; returns at posedge+1 (drive point).
  task automatic step();
    logic [NREQ-1:0] popMask;
    @(posedge clk);
    popMask = rd_en;
    #1;
    if (popMask[0]) begin
      check("pop_nonempty0", 64'(fifo0.size() > 0), 64'd1);
      if (fifo0.size() > 0) void'(fifo0.pop_front());
    end
    if (popMask[1]) begin
      check("pop_nonempty1", 64'(fifo1.size() > 0), 64'd1);
      if (fifo1.size() > 0) void'(fifo1.pop_front());
    end
    refresh();
  endtask

  task automatic push(input int src, input bit eop, input bit sop, input logic [31:0] d,
                      input bit expectIt);
    logic [WW-1:0] w;
    w = {eop, sop, d};
    if (src == 0) fifo0.push_back(w);
    else fifo1.push_back(w);
    if (expectIt) expQ.push_back(w);
    refresh();
  endtask

  task automatic pushPkt(input int src, input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) push(src, k == n - 1, k == 0, base + 32'(k), 1'b1);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check({name, "_drained"}, 64'(expQ.size()), 64'd0);
    step();
  endtask

  task automatic waitWord(input string name, input logic [31:0] d);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      @(negedge clk);
      if (out_valid && out_data == d) found = 1'b1;
    end
    check({name, "_seen"}, 64'(found), 64'd1);
  endtask

  initial begin
    int errBase;
    int base0;
    int base1;
    reset = 1'b0;
    in_req = '0;
    out_ready = 1'b0;
    refresh();
    step();
    step();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_outs", 64'({out_data, out_sop, out_eop, port_stall, err_proto}), 64'd0);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step();

    // Single 4-word packet: timing of arbitration, first pop and first output.
    in_req = 2'b01;
    push(0, 1'b0, 1'b1, 32'h0000ABCD, 1'b1);
    push(0, 1'b0, 1'b0, 32'd1, 1'b1);
    push(0, 1'b0, 1'b0, 32'd2, 1'b1);
    push(0, 1'b1, 1'b0, 32'd3, 1'b1);
    @(negedge clk);
    check("t2_grant_arb", 64'(grant), 64'd0);
    step();
    @(negedge clk);
    check("t2_grant", 64'(grant), 64'd1);
    check("t2_rd_en", 64'(rd_en), 64'd1);
    step();
    @(negedge clk);
    check("t2_first_valid", 64'(out_valid), 64'd1);
    check("t2_first_word", 64'({out_sop, out_data}), 64'({1'b1, 32'h0000ABCD}));
    waitDrain("t2");
    check("t2_grant_released", 64'(grant), 64'd0);

    // Single-word packet from requester 1 (also moves rr pointer back to 0).
    in_req = 2'b10;
    push(1, 1'b1, 1'b1, 32'h01000055, 1'b1);
    waitDrain("single");

    // Contention: pkt0 then pkt1, one idle cycle between.
    in_req = 2'b11;
    gapStart = cyc;
    gapChk = 1'b1;
    pushPkt(0, 3, 32'h00000100);
    pushPkt(1, 3, 32'h01000200);
    waitDrain("t3");

    // Fairness: 10 two-word packets per requester, strictly alternating.
    gapStart = cyc;
    base0 = sopCnt0;
    base1 = sopCnt1;
    for (int p = 0; p < 10; p++) begin
      pushPkt(0, 2, {8'h00, 8'(p), 16'h0000});
      pushPkt(1, 2, {8'h01, 8'(p), 16'h0000});
    end
    waitDrain("t4");
    gapChk = 1'b0;
    check("t4_count0", 64'(sopCnt0 - base0), 64'd10);
    check("t4_count1", 64'(sopCnt1 - base1), 64'd10);

    // Backpressure mid-packet.
    in_req = 2'b01;
    pushPkt(0, 6, 32'h00005000);
    waitWord("t5", 32'h00005001);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_hold_data", 64'({out_valid, out_data}), 64'({1'b1, 32'h00005002}));
      check("t5_no_rd_en", 64'(rd_en), 64'd0);
      if (k > 0) check("t5_port_stall", 64'(port_stall), 64'd1);
      step();
    end
    out_ready = 1'b1;
    waitDrain("t5");

    // Framing error: stray sop inside a packet is forwarded and flagged once.
    errBase = errCnt;
    push(0, 1'b0, 1'b1, 32'h00008000, 1'b1);
    push(0, 1'b0, 1'b0, 32'h00008001, 1'b1);
    push(0, 1'b0, 1'b1, 32'h00008002, 1'b1);
    push(0, 1'b1, 1'b0, 32'h00008003, 1'b1);
    waitDrain("framing");
    check("framing_err_count", 64'(errCnt - errBase), 64'd1);

    // Reset mid-transfer.
    in_req = 2'b10;
    pushPkt(1, 6, 32'h01006000);
    waitWord("t1", 32'h01006001);
    step();
    reset = 1'b0;
    #1;
    check("t1_valid", 64'(out_valid), 64'd0);
    check("t1_grant", 64'(grant), 64'd0);
    check("t1_rd_en", 64'(rd_en), 64'd0);
    check("t1_outs", 64'({out_data, out_sop, out_eop, err_proto}), 64'd0);
    expQ.delete();
    fifo1.delete();
    refresh();
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    check("t1_grant_after", 64'(grant), 64'd0);

    // rr pointer restarts at 0 after reset.
    step();
    in_req = 2'b11;
    push(0, 1'b1, 1'b1, 32'h00007000, 1'b1);
    push(1, 1'b1, 1'b1, 32'h01007100, 1'b1);
    waitDrain("rr_after_reset");

    // Long packet without/with watchdog.
    in_req = 2'b01;
    errBase = errCnt;
`ifdef ETH_ARB_WDOG_EN
    for (int k = 0; k < 12; k++) begin
      if (k == 7) begin
        push(0, 1'b0, 1'b0, 32'h00009000 + 32'(k), 1'b0);
        expQ.push_back({1'b1, 1'b0, 32'h00009007});
      end else begin
        push(0, 1'b0, k == 0, 32'h00009000 + 32'(k), k < 8);
      end
    end
    waitDrain("t6");
    check("t6_grant", 64'(grant), 64'd0);
    check("t6_err_count", 64'(errCnt - errBase), 64'd1);
    for (int k = 0; k < 5; k++) step();
    check("t6_remainder_kept", 64'(fifo0.size()), 64'd4);
    check("t6_grant_idle", 64'(grant), 64'd0);
    fifo0.delete();
    refresh();
`else
    pushPkt(0, 12, 32'h00009000);
    waitDrain("long");
    check("long_grant", 64'(grant), 64'd0);
    check("long_err_count", 64'(errCnt - errBase), 64'd0);
`endif

    step();
    step();
    check("final_exp_empty", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
